// File: rtl/fd_pipe_buffer_if.sv
// Fetch->decode handshake bundle: fetch-side inputs, decode-side pre-split fields.
// The slave modport is the buffer; the master modport is the fetch/decode environment.
interface fd_pipe_buffer_if #(
  parameter int INST_W = 32,
  parameter int PC_W   = 12,
  parameter int CNT_W  = 4
);
  logic [INST_W-1:0] instIn;
  logic [PC_W-1:0]   seqNextPcIn;
  logic              inValid;
  logic              inReady;
  logic              outReady;
  logic              outValid;
  logic              flush;
  logic [4:0]        opcode;
  logic [4:0]        rd;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        shamt;
  logic [4:0]        aluOp;
  logic [16:0]       imm;
  logic [26:0]       t;
  logic [PC_W-1:0]   seqNextPcOut;
  logic [CNT_W-1:0]  count;

  modport slave (
    input  instIn, seqNextPcIn, inValid, outReady, flush,
    output inReady, outValid, opcode, rd, rs, rt, shamt, aluOp, imm, t,
           seqNextPcOut, count
  );

  modport master (
    output instIn, seqNextPcIn, inValid, outReady, flush,
    input  inReady, outValid, opcode, rd, rs, rt, shamt, aluOp, imm, t,
           seqNextPcOut, count
  );
endinterface

// File: rtl/fd_pipe_buffer.sv
// DEPTH-entry fetch->decode FIFO with flush and NOP bubble on empty.
// Optional macro FD_BYPASS_EN: zero-latency pass-through when the FIFO is empty.
module fd_pipe_buffer #(
  parameter int INST_W = 32,
  parameter int PC_W   = 12,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 4
) (
  input  logic            clock,
  input  logic            resetN,
  fd_pipe_buffer_if.slave bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ENT_W = INST_W + PC_W;

  logic [ENT_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              empty_s, full_s, bypass_s, push_s, pop_s;
  logic [INST_W-1:0] head_inst_s;
  logic [PC_W-1:0]   head_pc_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return PTR_W'(0);
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  // Handshake decode and next-state for pointers and occupancy
  always_comb begin
    empty_s  = (count_q == CNT_W'(0));
    full_s   = (count_q == CNT_W'(DEPTH));
`ifdef FD_BYPASS_EN
    bypass_s = empty_s & bus.inValid & ~bus.flush;
`else
    bypass_s = 1'b0;
`endif
    // A bypassed entry taken in the same cycle is never written
    push_s   = bus.inValid & ~full_s & ~(bypass_s & bus.outReady);
    pop_s    = ~empty_s & bus.outReady;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      wr_ptr_d = PTR_W'(0);
      rd_ptr_d = PTR_W'(0);
      count_d  = CNT_W'(0);
    end else begin
      if (push_s) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      wr_ptr_q <= PTR_W'(0);
      rd_ptr_q <= PTR_W'(0);
      count_q  <= CNT_W'(0);
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: outputs are masked whenever the FIFO is empty
  always_ff @(posedge clock) begin
    if (push_s && !bus.flush) begin
      mem_q[wr_ptr_q] <= {bus.seqNextPcIn, bus.instIn};
    end
  end

  // Head selection, NOP masking and ISA field split
  always_comb begin
    head_inst_s = INST_W'(0);
    head_pc_s   = PC_W'(0);
    if (bypass_s) begin
      head_inst_s = bus.instIn;
      head_pc_s   = bus.seqNextPcIn;
    end else if (!empty_s) begin
      head_inst_s = mem_q[rd_ptr_q][INST_W-1:0];
      head_pc_s   = mem_q[rd_ptr_q][ENT_W-1:INST_W];
    end else begin
      head_inst_s = INST_W'(0);
      head_pc_s   = PC_W'(0);
    end
    bus.outValid     = ~empty_s | bypass_s;
    bus.inReady      = ~full_s;
    bus.count        = count_q;
    bus.opcode       = head_inst_s[31:27];
    bus.rd           = head_inst_s[26:22];
    bus.rs           = head_inst_s[21:17];
    bus.rt           = head_inst_s[16:12];
    bus.shamt        = head_inst_s[11:7];
    bus.aluOp        = head_inst_s[6:2];
    bus.imm          = head_inst_s[16:0];
    bus.t            = head_inst_s[26:0];
    bus.seqNextPcOut = head_pc_s;
  end
endmodule
